// File: rtl/serial_word_adder.sv
// serial_word_adder: multi-precision adder for operands streamed least-significant word first.
// Each word goes through a DATA_WIDTH-bit full-adder ripple chain seeded either by the packet's
// carry-in (first word) or by the carry saved from the previous word. The result sits in a
// single-entry output register behind a valid/ready handshake on both sides.
module serial_word_adder #(
  parameter int unsigned DATA_WIDTH = 4,
  parameter int unsigned IDX_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Operand stream
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic                  in_ci,
  input  logic                  in_last,
  input  logic                  in_vld,
  output logic                  in_rd,
  // Result stream
  output logic [DATA_WIDTH-1:0] out_s,
  output logic                  out_co,
  output logic                  out_last,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic                  out_vld,
  input  logic                  out_rd
);

  typedef enum logic [0:0] {
    StFirst,
    StMid
  } state_e;

  localparam logic [IDX_WIDTH-1:0] IdxOne = IDX_WIDTH'(1);

  state_e                  state_q;
  logic                    cy_q;
  logic [IDX_WIDTH-1:0]    idx_q;

  logic [DATA_WIDTH-1:0]   out_s_q;
  logic                    out_co_q;
  logic                    out_last_q;
  logic [IDX_WIDTH-1:0]    out_idx_q;
  logic                    out_vld_q;

  logic                    in_xfer;
  logic                    c_in;
  logic [DATA_WIDTH:0]     chain;
  logic [DATA_WIDTH-1:0]   sum;

  // The register can take a new word whenever it is empty or being drained this cycle;
  // gating with rst_n keeps the source stalled while the block is held in reset.
  assign in_rd   = rst_n & (~out_vld_q | out_rd);
  assign in_xfer = in_vld & in_rd;

  // First word of a packet starts from the caller's carry; later words chain the saved carry.
  assign c_in = (state_q == StFirst) ? in_ci : cy_q;

  // Ripple chain of DATA_WIDTH full adders.
  always_comb begin
    chain    = '0;
    sum      = '0;
    chain[0] = c_in;
    for (int i = 0; i < int'(DATA_WIDTH); i++) begin
      sum[i]     = in_a[i] ^ in_b[i] ^ chain[i];
      chain[i+1] = (in_a[i] & in_b[i]) | (in_a[i] & chain[i]) | (in_b[i] & chain[i]);
    end
  end

  // Packet FSM, carry/index bookkeeping and the registered output stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StFirst;
      cy_q       <= 1'b0;
      idx_q      <= '0;
      out_s_q    <= '0;
      out_co_q   <= 1'b0;
      out_last_q <= 1'b0;
      out_idx_q  <= '0;
      out_vld_q  <= 1'b0;
    end else if (in_xfer) begin
      out_s_q    <= sum;
      out_co_q   <= chain[DATA_WIDTH];
      out_last_q <= in_last;
      out_idx_q  <= idx_q;
      out_vld_q  <= 1'b1;
      cy_q       <= chain[DATA_WIDTH];
      if (in_last) begin
        // A packet's final carry is reported but never leaks into the next packet.
        state_q <= StFirst;
        idx_q   <= '0;
      end else begin
        state_q <= StMid;
        idx_q   <= idx_q + IdxOne;
      end
    end else if (out_rd) begin
      // Drained with nothing new arriving: data fields keep their last values.
      out_vld_q <= 1'b0;
    end
  end

  assign out_s    = out_s_q;
  assign out_co   = out_co_q;
  assign out_last = out_last_q;
  assign out_idx  = out_idx_q;
  assign out_vld  = out_vld_q;

endmodule

// File: tb/tb_serial_word_adder.sv
// Bench for serial_word_adder: directed checks followed by a randomized packet stream whose
// results are checked against big-integer A+B+ci computed per packet.
module tb_serial_word_adder;

  localparam int DW   = 4;
  localparam int IW   = 8;
  localparam int BW   = 1232;  // holds 300 words plus the final carry
  localparam int NPK  = 120;
  localparam int MAXC = 60000;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_ci;
  logic          in_last;
  logic          in_vld;
  logic          in_rd;
  logic [DW-1:0] out_s;
  logic          out_co;
  logic          out_last;
  logic [IW-1:0] out_idx;
  logic          out_vld;
  logic          out_rd;

  int n_tests;
  int n_fail;

  serial_word_adder #(
    .DATA_WIDTH(DW),
    .IDX_WIDTH (IW)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_a    (in_a),
    .in_b    (in_b),
    .in_ci   (in_ci),
    .in_last (in_last),
    .in_vld  (in_vld),
    .in_rd   (in_rd),
    .out_s   (out_s),
    .out_co  (out_co),
    .out_last(out_last),
    .out_idx (out_idx),
    .out_vld (out_vld),
    .out_rd  (out_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // One word with the sink always ready; outputs are checked by the caller one cycle later.
  task automatic xfer(input logic [DW-1:0] a, input logic [DW-1:0] b, input logic ci,
                      input logic last);
    @(negedge clk);
    in_a    = a;
    in_b    = b;
    in_ci   = ci;
    in_last = last;
    in_vld  = 1'b1;
    out_rd  = 1'b1;
    @(posedge clk);
    #1;
    in_vld  = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [DW-1:0] s, input logic co,
                         input logic last, input logic [IW-1:0] idx);
    chk({tag, "_vld"}, 64'(out_vld), 64'(1));
    chk({tag, "_s"}, 64'(out_s), 64'(s));
    chk({tag, "_co"}, 64'(out_co), 64'(co));
    chk({tag, "_last"}, 64'(out_last), 64'(last));
    chk({tag, "_idx"}, 64'(out_idx), 64'(idx));
  endtask

  // Random-stream state
  logic [BW-1:0] pa, pb, res, expv;
  logic [BW-1:0] exp_q[$];
  int            len_q[$];
  int            cur_len, cur_i, sent, rxd, mc, cyc, elen;
  logic          cur_ci, have, stall;
  logic [DW-1:0] ps_s;
  logic          ps_co, ps_last;
  logic [IW-1:0] ps_idx;

  task automatic new_packet(input int p);
    cur_len = (p % 40 == 5) ? int'($urandom_range(300, 257)) : int'($urandom_range(40, 1));
    pa = '0;
    pb = '0;
    for (int i = 0; i < cur_len; i++) begin
      pa[i*DW +: DW] = DW'($urandom);
      pb[i*DW +: DW] = DW'($urandom);
    end
    cur_ci = 1'($urandom);
    cur_i  = 0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    in_a    = '0;
    in_b    = '0;
    in_ci   = 1'b0;
    in_last = 1'b0;
    in_vld  = 1'b0;
    out_rd  = 1'b1;

    // Reset state
    #2;
    chk("rst_vld", 64'(out_vld), 64'(0));
    chk("rst_s", 64'(out_s), 64'(0));
    chk("rst_co", 64'(out_co), 64'(0));
    chk("rst_last", 64'(out_last), 64'(0));
    chk("rst_idx", 64'(out_idx), 64'(0));
    chk("rst_in_rd", 64'(in_rd), 64'(0));
    #10;
    rst_n = 1'b1;

    // Single-word packet: 7+8+1 = 0x10
    xfer(4'h7, 4'h8, 1'b1, 1'b1);
    chk_out("single", 4'h0, 1'b1, 1'b1, 8'd0);

    // Carry chain across three words; ci on the middle word must be ignored
    xfer(4'hF, 4'h1, 1'b0, 1'b0);
    chk_out("chain0", 4'h0, 1'b1, 1'b0, 8'd0);
    xfer(4'h0, 4'h0, 1'b1, 1'b0);
    chk_out("chain1", 4'h1, 1'b0, 1'b0, 8'd1);
    xfer(4'hF, 4'h0, 1'b0, 1'b1);
    chk_out("chain2", 4'hF, 1'b0, 1'b1, 8'd2);

    // Packet isolation: carry of a last word must not reach the next packet
    xfer(4'hF, 4'hF, 1'b0, 1'b1);
    chk_out("iso1", 4'hE, 1'b1, 1'b1, 8'd0);
    xfer(4'h0, 4'h0, 1'b0, 1'b1);
    chk_out("iso2", 4'h0, 1'b0, 1'b1, 8'd0);

    // Reset mid-packet: saved carry would be 1, so a stale MID state would give 0x8
    xfer(4'h1, 4'h1, 1'b0, 1'b0);
    xfer(4'hF, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    out_rd = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_vld", 64'(out_vld), 64'(0));
    chk("midrst_in_rd", 64'(in_rd), 64'(0));
    #1;
    rst_n = 1'b1;
    xfer(4'h3, 4'h4, 1'b0, 1'b1);
    chk_out("midrst_word", 4'h7, 1'b0, 1'b1, 8'd0);

    // Drain before the random stream
    @(negedge clk);
    out_rd = 1'b1;
    @(posedge clk);
    #1;
    chk("drain_vld", 64'(out_vld), 64'(0));

    // Randomized stream with random valid/ready
    sent  = 0;
    rxd   = 0;
    mc    = 0;
    cyc   = 0;
    res   = '0;
    stall = 1'b0;
    have  = 1'b1;
    new_packet(0);
    while (rxd < NPK && cyc < MAXC) begin
      @(negedge clk);
      cyc++;
      if (stall) begin
        chk("stall_s", 64'(out_s), 64'(ps_s));
        chk("stall_co", 64'(out_co), 64'(ps_co));
        chk("stall_last", 64'(out_last), 64'(ps_last));
        chk("stall_idx", 64'(out_idx), 64'(ps_idx));
        chk("stall_vld", 64'(out_vld), 64'(1));
      end
      in_vld = have && ($urandom_range(3) != 0);
      if (in_vld) begin
        in_a    = pa[cur_i*DW +: DW];
        in_b    = pb[cur_i*DW +: DW];
        in_ci   = (cur_i == 0) ? cur_ci : 1'($urandom);
        in_last = (cur_i == cur_len - 1);
      end else begin
        in_a    = DW'($urandom);
        in_b    = DW'($urandom);
        in_ci   = 1'($urandom);
        in_last = 1'($urandom);
      end
      out_rd = ($urandom_range(3) != 0);
      #1;
      chk("in_rd", 64'(in_rd), 64'(!out_vld || out_rd));
      if (out_vld && out_rd) begin
        chk("rx_idx", 64'(out_idx), 64'(mc % 256));
        res[mc*DW +: DW] = out_s;
        mc++;
        if (out_last) begin
          res[mc*DW] = out_co;
          if (exp_q.size() == 0) begin
            chk("rx_unexpected_packet", 64'(1), 64'(0));
          end else begin
            expv = exp_q.pop_front();
            elen = len_q.pop_front();
            chk("rx_len", 64'(mc), 64'(elen));
            n_tests++;
            assert (res === expv)
            else begin
              n_fail++;
              $error("FAIL rx_sum pkt %0d: observed low bits %0h expected %0h", rxd,
                     res[255:0], expv[255:0]);
            end
          end
          rxd++;
          mc  = 0;
          res = '0;
        end
      end
      if (in_vld && in_rd) begin
        if (cur_i == cur_len - 1) begin
          exp_q.push_back(pa + pb + BW'(cur_ci));
          len_q.push_back(cur_len);
          sent++;
          if (sent < NPK) new_packet(sent);
          else have = 1'b0;
        end else begin
          cur_i++;
        end
      end
      stall   = out_vld && !out_rd;
      ps_s    = out_s;
      ps_co   = out_co;
      ps_last = out_last;
      ps_idx  = out_idx;
    end
    chk("stream_packets_received", 64'(rxd), 64'(NPK));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
